// File: rtl/prbs_word_if.sv
// Valid/ready word bus between the PRBS source and its downstream consumer.
interface prbs_word_if #(
  parameter int WIDTH = 8
) ();
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] prbs_out;

  modport master (output out_valid, output prbs_out, input out_ready);
  modport slave  (input out_valid, input prbs_out, output out_ready);
endinterface

// File: rtl/prbs_word_generator.sv
// PRBS7/15/23/31 word source with seed reload, valid/ready output, single-bit
// error injection and an accepted-word counter.
//
// state | meaning
// IDLE  | no word presented; waits for enable
// LOAD  | first word after reset/seed load is being generated
// RUN   | word presented on out_valid, advances on each accept
module prbs_word_generator #(
  parameter int          WIDTH      = 8,
  parameter int          PRBS_ORDER = 15,
  parameter logic [30:0] INIT_SEED  = 31'h7FFF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               seed_load,
  input  logic [30:0]        seed_value,
  input  logic               inject_error,
  prbs_word_if.master        out_if,
  output logic [31:0]        word_count,
  output logic               seed_zero
);

  localparam int TAP = (PRBS_ORDER == 7)  ? 6  :
                       (PRBS_ORDER == 15) ? 14 :
                       (PRBS_ORDER == 23) ? 18 : 28;

  localparam logic [PRBS_ORDER-1:0] INIT_LFSR =
    (INIT_SEED[PRBS_ORDER-1:0] == '0) ? '1 : INIT_SEED[PRBS_ORDER-1:0];

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                r_state;
  logic [PRBS_ORDER-1:0] r_lfsr;
  logic [WIDTH-1:0]      r_word;
  logic                  r_valid;
  logic [31:0]           r_count;
  logic                  r_seed_zero;
  logic                  r_fresh;
  logic                  r_err_req;
  logic                  r_err_inword;

  logic [PRBS_ORDER-1:0] w_lfsr_next;
  logic [WIDTH-1:0]      w_word;
  logic [WIDTH-1:0]      w_word_out;
  logic [PRBS_ORDER-1:0] w_seed_bits;
  logic [PRBS_ORDER-1:0] w_seed_lfsr;
  logic                  w_seed_is_zero;
  logic                  w_accept;
  logic                  w_flip;
  logic                  w_unused_seed;

  // All WIDTH bit steps unrolled; the first generated bit lands in the MSB.
  always_comb begin : gen_word
    logic [PRBS_ORDER-1:0] v_s;
    logic                  v_bit;
    v_s    = r_lfsr;
    v_bit  = 1'b0;
    w_word = '0;
    for (int i = 0; i < WIDTH; i++) begin
      v_bit = v_s[PRBS_ORDER-1] ^ v_s[TAP-1];
      v_s   = {v_s[PRBS_ORDER-2:0], v_bit};
      w_word[WIDTH-1-i] = v_bit;
    end
    w_lfsr_next = v_s;
  end

  // The error request is applied to the next word entering the output register,
  // so a word already on the bus never changes while it waits for ready.
  assign w_flip = r_err_req | (inject_error & ~r_err_inword);

  always_comb begin
    w_word_out    = w_word;
    w_word_out[0] = w_word[0] ^ w_flip;
  end

  assign w_seed_bits    = seed_value[PRBS_ORDER-1:0];
  assign w_seed_is_zero = (w_seed_bits == '0);
  assign w_seed_lfsr    = w_seed_is_zero ? '1 : w_seed_bits;
  assign w_accept       = r_valid & out_if.out_ready;
  assign w_unused_seed  = ^seed_value;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_lfsr       <= INIT_LFSR;
      r_word       <= '0;
      r_valid      <= 1'b0;
      r_count      <= '0;
      r_seed_zero  <= 1'b0;
      r_fresh      <= 1'b1;
      r_err_req    <= 1'b0;
      r_err_inword <= 1'b0;
    end else begin
      r_seed_zero <= 1'b0;
      if (seed_load) begin
        r_lfsr       <= w_seed_lfsr;
        r_count      <= '0;
        r_valid      <= 1'b0;
        r_fresh      <= 1'b1;
        r_err_req    <= 1'b0;
        r_err_inword <= 1'b0;
        r_seed_zero  <= w_seed_is_zero;
        r_state      <= enable ? LOAD : IDLE;
      end else begin
        if (inject_error && !r_err_req && !r_err_inword) begin
          r_err_req <= 1'b1;
        end
        case (r_state)
          IDLE: begin
            if (enable) begin
              if (r_fresh) begin
                r_state <= LOAD;
              end else begin
                r_state <= RUN;
                r_valid <= 1'b1;
              end
            end
          end
          LOAD: begin
            r_word  <= w_word_out;
            r_lfsr  <= w_lfsr_next;
            r_valid <= 1'b1;
            r_fresh <= 1'b0;
            r_state <= RUN;
            if (w_flip) begin
              r_err_req    <= 1'b0;
              r_err_inword <= 1'b1;
            end
          end
          RUN: begin
            if (w_accept) begin
              r_count      <= r_count + 32'd1;
              r_word       <= w_word_out;
              r_lfsr       <= w_lfsr_next;
              r_err_inword <= 1'b0;
              if (w_flip) begin
                r_err_req    <= 1'b0;
                r_err_inword <= 1'b1;
              end
              // A word prepared here while disabled is held and shown on re-enable.
              if (!enable) begin
                r_valid <= 1'b0;
                r_state <= IDLE;
              end
            end
          end
          default: begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_if.out_valid = r_valid;
  assign out_if.prbs_out  = r_word;
  assign word_count       = r_count;
  assign seed_zero        = r_seed_zero;

endmodule
